// File: rtl/fade_envelope_gen.sv
// -----------------------------------------------------------------------------
// fade_envelope_gen
//  Breathing-envelope generator feeding the gamma-LUT / PWM stage. Produces an
//  LW-bit brightness index that ramps as a triangle (0 -> MAX -> 0) or a
//  sawtooth (0 -> MAX, drop to 0), with a programmable step rate and dwell at
//  the top and bottom. Each new level is offered over a valid/ready handshake
//  so the consumer can latch it on its own period boundary; a stalled consumer
//  stalls the envelope (including dwell steps) rather than skipping values.
//
// Ports
//  CLK          in   1       system clock, rising edge
//  RST_N        in   1       asynchronous active-low reset
//  en           in   1       run enable; low forces IDLE and discards a pending sample
//  mode         in   1       0 = triangle, 1 = sawtooth
//  step_div     in   DIV_W   one envelope step every step_div+1 cycles
//  hold_top     in   HOLD_W  dwell steps at MAX
//  hold_bot     in   HOLD_W  dwell steps at 0
//  level        out  LW      current envelope value
//  level_valid  out  1       level holds an unconsumed sample
//  level_ready  in   1       consumer accepts level this cycle
//  cycle_done   out  1       one-cycle pulse when a full envelope period completes
// -----------------------------------------------------------------------------
module fade_envelope_gen #(
  parameter int unsigned LW     = 8,
  parameter int unsigned DIV_W  = 17,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  input  logic              mode,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_top,
  input  logic [HOLD_W-1:0] hold_bot,
  output logic [LW-1:0]     level,
  output logic              level_valid,
  input  logic              level_ready,
  output logic              cycle_done
);

  localparam logic [LW-1:0] LVL_MAX    = '1;
  localparam logic [LW-1:0] LVL_MAX_M1 = LVL_MAX - LW'(1);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  presc;
  logic [HOLD_W-1:0] hold_cnt;

  logic tick_c;
  logic adv_c;
  logic xfer_c;

  // A step is taken only when the output slot is free or being drained this
  // cycle; otherwise the tick is dropped. '>=' (rather than '==') keeps the
  // prescaler from running away if step_div is lowered below its count.
  assign tick_c = (presc >= step_div);
  assign adv_c  = tick_c & (~level_valid | level_ready);
  assign xfer_c = level_valid & level_ready;

  // Envelope state machine, prescaler and handshake registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      presc       <= '0;
      hold_cnt    <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      cycle_done <= 1'b0;

      if (!en) begin
        // Level keeps its last value; the pending sample is discarded.
        state       <= IDLE;
        presc       <= '0;
        hold_cnt    <= '0;
        level_valid <= 1'b0;
      end else if (state == IDLE) begin
        // Every run starts by offering level 0.
        state       <= RISE;
        presc       <= '0;
        hold_cnt    <= '0;
        level       <= '0;
        level_valid <= 1'b1;
      end else begin
        presc <= tick_c ? '0 : presc + DIV_W'(1);

        // Drain first; a sample produced below in the same cycle overrides.
        if (xfer_c) begin
          level_valid <= 1'b0;
        end

        if (adv_c) begin
          case (state)
            RISE: begin
              level       <= level + LW'(1);
              level_valid <= 1'b1;
              if (level == LVL_MAX_M1) begin
                state    <= HOLD_HI;
                hold_cnt <= '0;
              end
            end

            // mode / hold_top are sampled here, at the decision point.
            HOLD_HI: begin
              if (hold_cnt < hold_top) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end else begin
                hold_cnt    <= '0;
                level_valid <= 1'b1;
                if (mode) begin
                  state <= HOLD_LO;
                  level <= '0;
                end else begin
                  state <= FALL;
                  level <= LVL_MAX_M1;
                end
              end
            end

            FALL: begin
              level       <= level - LW'(1);
              level_valid <= 1'b1;
              if (level == LVL_ONE) begin
                state    <= HOLD_LO;
                hold_cnt <= '0;
              end
            end

            // Leaving the bottom dwell closes one envelope period.
            HOLD_LO: begin
              if (hold_cnt < hold_bot) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end else begin
                hold_cnt    <= '0;
                state       <= RISE;
                level       <= LVL_ONE;
                level_valid <= 1'b1;
                cycle_done  <= 1'b1;
              end
            end

            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
